// File: rtl/calc_hist.sv
// Board calculator with undo history, overflow/zero flags and edge-triggered buttons.
// Define CALC_MUL_EN to add the sequential shift-add multiply (btnm extended op).
module calc_hist #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         btnu,
    input  logic                         btnl,
    input  logic                         btnc,
    input  logic                         btnr,
    input  logic                         btnm,
    input  logic                         btnd,
    input  logic                         btnx,
    input  logic [WIDTH-1:0]             sw,
    output logic [WIDTH-1:0]             led,
    output logic                         zero,
    output logic                         ovf,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   hist_cnt
);

    localparam int SW_BITS = $clog2(WIDTH);
    localparam int CW      = $clog2(DEPTH+1);
    localparam int PW      = $clog2(DEPTH);

    logic [2:0]         d_sync, x_sync;
    logic               exe_p, undo_p;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   hist [DEPTH];
    logic [PW-1:0]      top, top_inc, top_dec;
    logic [2:0]         op;
    logic [SW_BITS-1:0] shamt;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf;
    logic               commit, undo;
    logic [WIDTH-1:0]   commit_val;
    logic               commit_ovf;

    // Bits [1:0] synchronise, bit [2] is the previous value for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) begin
            d_sync <= '0;
            x_sync <= '0;
        end else begin
            d_sync <= {d_sync[1:0], btnd};
            x_sync <= {x_sync[1:0], btnx};
        end
    end

    assign exe_p  = d_sync[1] & ~d_sync[2];
    assign undo_p = x_sync[1] & ~x_sync[2];

    assign op    = {btnl, btnc, btnr};
    assign shamt = sw[SW_BITS-1:0];
    assign sum   = acc + sw;
    assign diff  = acc - sw;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            3'b000: alu_res = acc & sw;
            3'b001: alu_res = acc | sw;
            3'b010: begin
                alu_res = sum;
                alu_ovf = (acc[WIDTH-1] == sw[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);
            end
            3'b011: begin
                alu_res = diff;
                alu_ovf = (acc[WIDTH-1] != sw[WIDTH-1]) && (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            3'b100: alu_res = {{(WIDTH-1){1'b0}}, ($signed(acc) < $signed(sw))};
            3'b101: alu_res = acc << shamt;
            3'b110: alu_res = $signed(acc) >>> shamt;
            default: alu_res = acc ^ sw;
        endcase
    end

`ifdef CALC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t               state_q, state_d;
    logic                 start_mul;
    logic [2*WIDTH-1:0]   mcand, prod, prod_next;
    logic [WIDTH-1:0]     mult;
    logic [SW_BITS-1:0]   mul_cnt;

    assign prod_next = prod + (mult[0] ? mcand : '0);

    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        start_mul  = 1'b0;
        commit     = 1'b0;
        undo       = 1'b0;
        commit_val = alu_res;
        commit_ovf = alu_ovf;
        case (state_q)
            IDLE: begin
                if (exe_p) begin
                    if (btnm) begin
                        start_mul = 1'b1;
                        state_d   = MUL;
                    end else begin
                        commit = 1'b1;
                    end
                end else if (undo_p && hist_cnt != '0) begin
                    undo = 1'b1;
                end
            end
            MUL: begin
                // Last partial product is folded in on the same edge as the commit.
                if (mul_cnt == SW_BITS'(WIDTH-1)) begin
                    commit     = 1'b1;
                    commit_val = prod_next[WIDTH-1:0];
                    commit_ovf = |prod_next[2*WIDTH-1:WIDTH];
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) begin
            mcand   <= '0;
            mult    <= '0;
            prod    <= '0;
            mul_cnt <= '0;
        end else if (start_mul) begin
            mcand   <= {{WIDTH{1'b0}}, acc};
            mult    <= sw;
            prod    <= '0;
            mul_cnt <= '0;
        end else if (state_q == MUL) begin
            prod    <= prod_next;
            mcand   <= mcand << 1;
            mult    <= mult >> 1;
            mul_cnt <= mul_cnt + 1'b1;
        end
    end

    assign busy = (state_q == MUL);
`else
    logic unused_btnm;
    assign unused_btnm = btnm;

    always_comb begin
        commit     = exe_p;
        undo       = undo_p && !exe_p && (hist_cnt != '0);
        commit_val = alu_res;
        commit_ovf = alu_ovf;
    end

    assign busy = 1'b0;
`endif

    assign top_inc = (top == PW'(DEPTH-1)) ? '0 : top + 1'b1;
    assign top_dec = (top == '0) ? PW'(DEPTH-1) : top - 1'b1;

    always_ff @(posedge clk or negedge btnu) begin
        if (!btnu) begin
            acc      <= '0;
            ovf      <= 1'b0;
            top      <= '0;
            hist_cnt <= '0;
        end else if (commit) begin
            acc <= commit_val;
            ovf <= commit_ovf;
            top <= top_inc;
            if (hist_cnt != CW'(DEPTH)) hist_cnt <= hist_cnt + 1'b1;
        end else if (undo) begin
            acc      <= hist[top_dec];
            top      <= top_dec;
            hist_cnt <= hist_cnt - 1'b1;
            ovf      <= 1'b0;
        end
    end

    // NOTE: history storage has no reset; hist_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (commit) hist[top] <= acc;
    end

    assign led  = acc;
    assign zero = (acc == '0);

endmodule

// File: doc/calc_hist.md
# calc_hist

Parametrised successor to the board calculator. A WIDTH-bit signed accumulator is updated from the switches under control of the three op-select buttons. It adds synchronised edge-triggered buttons, an undo history of DEPTH previous accumulator values, overflow/zero flags, and an optional multi-cycle multiply. It sits between the board I/O (buttons, switches, LEDs) and nothing else; `led` is the accumulator.

## Interface

- `WIDTH`, default 16: accumulator, switch and LED width; must be ≥ 4.
- `DEPTH`, default 8: undo-history entries; must be ≥ 2.
- `clk` input, 1 bit: single clock; everything is clocked on the rising edge.
- `btnu` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `btnl`, `btnc`, `btnr` inputs, 1 bit each: opcode `{btnl,btnc,btnr}`, sampled at execute.
- `btnm` input, 1 bit: extended-op select (multiply). Ignored unless `CALC_MUL_EN` is defined.
- `btnd` input, 1 bit: execute button; asynchronous and edge-triggered.
- `btnx` input, 1 bit: undo button; asynchronous and edge-triggered.
- `sw` input, WIDTH bits: operand B.
- `led` output, WIDTH bits: accumulator.
- `zero` output, 1 bit: `led == 0`, combinational from the accumulator register.
- `ovf` output, 1 bit: signed overflow of the last committed op.
- `busy` output, 1 bit: multiply in progress.
- `hist_cnt` output, $clog2(DEPTH+1) bits: number of valid history entries.

## Operation

- **Button conditioning.**
  - `btnd` and `btnx` each pass through a 2-FF synchroniser and then a rising-edge detector.
  - Each press produces exactly one 1-cycle pulse: `exe_p` or `undo_p`. Holding a button produces no further pulses.
- **Opcodes on `exe_p` with `btnm`=0** (A = acc, B = `sw`, S = `sw[$clog2(WIDTH)-1:0]`):
  - 000 AND.
  - 001 OR.
  - 010 ADD.
  - 011 SUB (A−B).
  - 100 LT: signed A<B gives 1, otherwise 0.
  - 101 LSL: A<<S.
  - 110 SRA: A>>>S.
  - 111 XOR.
- **Arithmetic rules.**
  - All results are truncated to WIDTH bits.
  - `ovf` is set for ADD/SUB when the signed result wraps. For every other op, `ovf` is 0.
  - `ovf` is updated only on commit.
- **Commit.**
  - The old acc is pushed onto the history, and acc takes the result.
  - The opcode and `sw` are sampled in the same cycle as `exe_p`.
- **History.**
  - Circular buffer with a top pointer.
  - Push when `hist_cnt`==DEPTH: the oldest entry is overwritten and `hist_cnt` stays at DEPTH.
- **Undo on `undo_p`.**
  - If `hist_cnt`>0: acc is restored from the top entry, `hist_cnt` decrements, and `ovf` clears.
  - If `hist_cnt`==0: no effect.
- **Simultaneous events.**
  - `exe_p` and `undo_p` in the same cycle: execute wins and the undo is dropped.
  - Pulses arriving while `busy`=1 are dropped; they are not queued.
- **State machine** (`IDLE`, `MUL`):
  - `IDLE`→`MUL` on `exe_p` with `btnm`=1 (only when `CALC_MUL_EN` is defined).
  - `MUL`→`IDLE` after WIDTH iterations, committing the result.

## Timing

- **Reset values:** `led`=0, `zero`=1, `ovf`=0, `busy`=0, `hist_cnt`=0, state `IDLE`. The synchroniser and edge-detector flops are also 0.
- **Reset mid-operation:** asserting `btnu` low at any time immediately aborts a multiply and clears everything. No partial result is committed.
- **Execute latency:**
  - `btnd` first sampled high at edge k.
  - `exe_p` is high during cycle k+1..k+2.
  - `led`/`ovf`/`hist_cnt` update at edge k+2.
  - `btnd` must stay high ≥2 cycles to be captured.
- **Undo latency:** identical to execute.
- **Multiply latency:**
  - `busy` rises at edge k+2.
  - The result commits and `busy` falls at edge k+2+WIDTH.
  - `led` holds the old acc until commit.

## Configuration

- `CALC_MUL_EN` defined:
  - Sequential shift-add multiply, one partial product per cycle.
  - Result is the low WIDTH bits of the unsigned product acc×`sw`.
  - `ovf` is set if the high WIDTH bits are non-zero.
  - The multiply pushes to the history like any other op.
- `CALC_MUL_EN` undefined:
  - `btnm` is ignored, and execute always uses the 3-bit opcode.
  - No `MUL` state or multiplier datapath exists.
  - `busy` is tied to 0.
  - The port list is unchanged.

## Test plan

- **Reset:** `btnu` low mid-sequence → `led`=0, `zero`=1, `hist_cnt`=0, `ovf`=0 immediately, without waiting for `clk`.
- **Op chain** (WIDTH=16; each step holds `btnd` 3 cycles and releases 3 cycles):
  - ADD 0x354A → 0x354A.
  - SUB 0x1234 → 0x2316.
  - OR 0x1001 → 0x3317.
  - AND 0xF0F0 → 0x3010.
  - XOR 0x1FA2 → 0x2FB2.
  - ADD 0x6AA2 → 0x9A54 with `ovf`=1.
  - SRA 1 → 0xCD2A.
  - LT 0x46FF → 0x0001.
- **Edge-only execute:** ADD with `sw`=1, `btnd` held 20 cycles → `led` increments exactly once.
- **Undo:**
  - After the 8-op chain with DEPTH=8: `hist_cnt`=8; three undos → `led`=0x2FB2, `hist_cnt`=5.
  - Nine ops then nine undos → the 9th undo has no effect, `hist_cnt`=0, `led`=0x354A.
- **Simultaneous:** `btnd` and `btnx` rising on the same edge with ADD `sw`=2, `led`=5 → `led`=7, `hist_cnt` +1.
- **Multiply** (`CALC_MUL_EN` defined, acc=0x0003, `sw`=0x0005, `btnm`=1):
  - `busy` is high for 16 cycles; then `led`=0x000F, `ovf`=0.
  - A `btnd` press during `busy` is ignored.
  - acc=0x0100 × 0x0100 → `led`=0, `ovf`=1, `zero`=1.
